// File: rtl/dmem_fb.sv
// Single-port 32-bit data memory shared by a CPU port and a framebuffer scanner.
// The scanner streams a window of the array as RGB565 pixels; CPU accesses always win the port.
module dmem_fb #(
    parameter int ADDR_W   = 10,
    parameter int FB_BASE  = 0,
    parameter int FB_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        pix_start,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_last,
    output logic        pix_busy
);

    localparam int                 DEPTH     = 2 ** ADDR_W;
    localparam int                 PTR_W     = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W-1:0]  FB_BASE_A = ADDR_W'(FB_BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    logic [31:0]       mem_r [DEPTH];
    state_t            state_r;
    logic [PTR_W-1:0]  ptr_r;
    logic              half_r;
    logic [31:0]       fetch_r;
    logic [31:0]       hold_r;

    logic [ADDR_W-1:0] cpu_idx_s;
    logic [ADDR_W-1:0] fb_idx_s;
    logic [ADDR_W-1:0] arr_idx_s;
    logic [31:0]       arr_q_s;
    logic              fetch_go_s;
    logic              hs_s;
    logic              unused_s;

    assign unused_s = &{1'b0, cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    // Port arbitration: the scanner only gets the array in cycles the CPU leaves idle.
    always_comb begin
        cpu_idx_s = cpu_addr[ADDR_W+1:2];
        fb_idx_s  = FB_BASE_A + ADDR_W'(ptr_r);
        if (cpu_req) begin
            arr_idx_s = cpu_idx_s;
        end else begin
            arr_idx_s = fb_idx_s;
        end
        arr_q_s    = mem_r[arr_idx_s];
        fetch_go_s = (state_r == ST_FETCH) && !cpu_req;
        hs_s       = pix_valid && pix_ready;
    end

    // Byte-lane array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (cpu_req && cpu_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cpu_be[i]) begin
                    mem_r[cpu_idx_s][8*i +: 8] <= cpu_wdata[8*i +: 8];
                end
            end
        end
    end

    // CPU response: one-cycle ack, read data held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= 32'd0;
        end else begin
            cpu_ack <= cpu_req;
            if (cpu_req && !cpu_we) begin
                cpu_rdata <= arr_q_s;
            end
        end
    end

    // Scanner FSM with registered pixel stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            half_r    <= 1'b0;
            fetch_r   <= 32'd0;
            hold_r    <= 32'd0;
            pix_valid <= 1'b0;
            pix_data  <= 16'd0;
            pix_last  <= 1'b0;
            pix_busy  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pix_start) begin
                        ptr_r    <= '0;
                        half_r   <= 1'b0;
                        pix_busy <= 1'b1;
                        state_r  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_go_s) begin
                        fetch_r <= arr_q_s;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    hold_r    <= fetch_r;
                    half_r    <= 1'b0;
                    pix_data  <= fetch_r[15:0];
                    pix_valid <= 1'b1;
                    pix_last  <= 1'b0;
                    state_r   <= ST_SEND;
                end
                ST_SEND: begin
                    if (hs_s) begin
                        if (!half_r) begin
                            half_r   <= 1'b1;
                            pix_data <= hold_r[31:16];
                            pix_last <= (ptr_r == PTR_LAST);
                        end else begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            if (ptr_r == PTR_LAST) begin
                                pix_busy <= 1'b0;
                                state_r  <= ST_IDLE;
                            end else begin
                                ptr_r   <= ptr_r + PTR_W'(1);
                                state_r <= ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_fb.sv
// Directed self-checking bench for dmem_fb: CPU byte lanes, aliasing, and the pixel scanner.
module tb_dmem_fb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        pix_start;
    logic        pix_ready;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_last;
    logic        pix_busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [15:0] exp_pix [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    dmem_fb #(.ADDR_W(10), .FB_BASE(4), .FB_WORDS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .pix_start(pix_start), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_last(pix_last), .pix_busy(pix_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   {31'd0, cpu_ack},   32'd0);
        chk({tag, "_rdata"}, cpu_rdata,          32'd0);
        chk({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_data"},  {16'd0, pix_data},  32'd0);
        chk({tag, "_last"},  {31'd0, pix_last},  32'd0);
        chk({tag, "_busy"},  {31'd0, pix_busy},  32'd0);
    endtask

    // Drive one CPU request for the current cycle (called at a negedge).
    task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
    endtask

    function automatic logic ready_at(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return (cyc % 3) == 0;
    endfunction

    // Runs one frame; mode 1 = 1-on/2-off backpressure, contend = CPU busy cycles from the
    // first FETCH cycle, abort_at = pixel count after which reset is pulsed (0 = none).
    task automatic run_scan(input int mode, input int contend, input int abort_at);
        int n = 0;
        int first = -1;
        bit done = 1'b0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [15:0] pd = 16'd0;
        @(negedge clk);
        pix_start = 1'b1;
        pix_ready = ready_at(mode, 0);
        for (int cyc = 1; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            pix_start = 1'b0;
            if (contend > 0) begin
                if (cyc >= 2 && cyc <= contend + 1) chk("contend_ack", {31'd0, cpu_ack}, 32'd1);
                cpu_req = (cyc <= contend);
                cpu_we  = 1'b0;
                cpu_addr = 32'h0000_0040;
            end
            pix_ready = ready_at(mode, cyc);
            if (pv && !pr) begin
                chk("stall_valid", {31'd0, pix_valid}, 32'd1);
                chk("stall_data", {16'd0, pix_data}, {16'd0, pd});
            end
            if (pix_valid && first < 0) begin
                first = cyc;
                chk("first_valid_cycle", first, 3 + contend);
            end
            pv = pix_valid; pr = pix_ready; pd = pix_data;
            if (pix_valid && pix_ready) begin
                chk("pix_data", {16'd0, pix_data}, {16'd0, exp_pix[n]});
                chk("pix_last", {31'd0, pix_last}, (n == 3) ? 32'd1 : 32'd0);
                n++;
                if (abort_at != 0 && n == abort_at) begin
                    done = 1'b1;
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("abort");
                    @(negedge clk);
                    rst_n = 1'b1;
                    pix_ready = 1'b1;
                    repeat (3) @(negedge clk);
                    chk("abort_no_resume_busy", {31'd0, pix_busy}, 32'd0);
                    chk("abort_no_resume_valid", {31'd0, pix_valid}, 32'd0);
                end else if (n == 4) begin
                    done = 1'b1;
                    @(negedge clk);
                    chk("end_busy", {31'd0, pix_busy}, 32'd0);
                    chk("end_valid", {31'd0, pix_valid}, 32'd0);
                end
            end
        end
        if (!done) chk("scan_timeout", n, 4);
        cpu_req = 1'b0;
        pix_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; pix_start = 1'b0; pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Byte-lane write then read back
        @(negedge clk); cpu_drive(1'b1, 32'h0, 32'h1122_3344, 4'b1111);
        @(negedge clk); chk("wr1_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_drive(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101);
        @(negedge clk); chk("wr2_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_drive(1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge clk); chk("rd_ack", {31'd0, cpu_ack}, 32'd1);
        chk("byte_lane_rdata", cpu_rdata, 32'h11BB_33DD);
        cpu_req = 1'b0;
        @(negedge clk); chk("ack_one_cycle", {31'd0, cpu_ack}, 32'd0);
        chk("rdata_hold", cpu_rdata, 32'h11BB_33DD);

        // Alias of an upper-bit address onto word 0, back-to-back with a read
        cpu_drive(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
        @(negedge clk); chk("alias_wr_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_drive(1'b0, 32'h0, 32'h0, 4'b0000);
        @(negedge clk); chk("alias_rd_ack", {31'd0, cpu_ack}, 32'd1);
        chk("alias_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Framebuffer contents: words 4 and 5
        cpu_drive(1'b1, 32'h10, 32'h2222_1111, 4'b1111);
        @(negedge clk); cpu_drive(1'b1, 32'h14, 32'h4444_3333, 4'b1111);
        @(negedge clk); cpu_drive(1'b0, 32'h14, 32'h0, 4'b0000);
        @(negedge clk); chk("fb_word5_rdata", cpu_rdata, 32'h4444_3333);
        cpu_req = 1'b0;
        @(negedge clk); chk("cpu_idle_ack", {31'd0, cpu_ack}, 32'd0);

        run_scan(0, 0, 0);
        run_scan(1, 0, 0);
        run_scan(0, 5, 0);
        run_scan(0, 0, 3);
        run_scan(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
